// File: rtl/hc165_scan_reader.sv
// Periodic scanner for a daisy-chain of 74HC165 shift registers; presents the chain as a parallel word.
// Define HC165_DEBOUNCE_EN to commit only words seen on two consecutive scans.
module hc165_scan_reader #(
    parameter int CHAIN_BITS = 16,
    parameter int CLK_DIV    = 25,
    parameter int SCAN_GAP   = 50000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  scan_en,
    output logic                  hc_ld_n,
    output logic                  hc_clk,
    input  logic                  hc_dat,
    output logic [CHAIN_BITS-1:0] data,
    output logic                  data_valid,
    output logic                  data_changed,
    output logic                  busy
);

    localparam int PH_W  = $clog2(CLK_DIV);
    localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam int BIT_W = $clog2(CHAIN_BITS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
    logic [CHAIN_BITS-1:0] shreg_q, shreg_d;
    logic [CHAIN_BITS-1:0] data_q, data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  data_changed_q, data_changed_d;
    logic                  hc_ld_n_q, hc_ld_n_d;
    logic                  hc_clk_q, hc_clk_d;
    logic                  busy_q, busy_d;
    logic                  dat_meta_q, dat_sync_q;
    logic                  phase_last;
`ifdef HC165_DEBOUNCE_EN
    logic [CHAIN_BITS-1:0] cand_q, cand_d;
    logic                  cand_vld_q, cand_vld_d;
`endif

    assign phase_last = (phase_q == PH_W'(CLK_DIV - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        phase_d        = (state_q == S_IDLE || phase_last) ? '0 : phase_q + 1'b1;
        gap_d          = gap_q;
        bitcnt_d       = bitcnt_q;
        shreg_d        = shreg_q;
        data_d         = data_q;
        data_valid_d   = 1'b0;
        data_changed_d = 1'b0;
`ifdef HC165_DEBOUNCE_EN
        cand_d         = cand_q;
        cand_vld_d     = cand_vld_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!scan_en) begin
                    gap_d = '0;
                end else if (gap_q == GAP_W'(SCAN_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_LOAD: begin
                bitcnt_d = '0;
                if (phase_last) state_d = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (phase_last) begin
                    shreg_d  = {shreg_q[CHAIN_BITS-2:0], dat_sync_q};
                    bitcnt_d = bitcnt_q + 1'b1;
                    state_d  = (bitcnt_q == BIT_W'(CHAIN_BITS - 1)) ? S_DONE : S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (phase_last) state_d = S_SHIFT_LO;
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef HC165_DEBOUNCE_EN
                // Candidate is always replaced; commit only on a repeat of the previous scan.
                cand_d     = shreg_q;
                cand_vld_d = 1'b1;
                if (cand_vld_q && (shreg_q == cand_q)) begin
                    data_d         = shreg_q;
                    data_valid_d   = 1'b1;
                    data_changed_d = (shreg_q != data_q);
                end
`else
                data_d         = shreg_q;
                data_valid_d   = 1'b1;
                data_changed_d = (shreg_q != data_q);
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Pins follow the next state so they switch on the same edge as the FSM.
        hc_ld_n_d = (state_d != S_LOAD);
        hc_clk_d  = (state_d == S_SHIFT_HI);
        busy_d    = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            gap_q          <= '0;
            bitcnt_q       <= '0;
            shreg_q        <= '0;
            data_q         <= '0;
            data_valid_q   <= 1'b0;
            data_changed_q <= 1'b0;
            hc_ld_n_q      <= 1'b1;
            hc_clk_q       <= 1'b0;
            busy_q         <= 1'b0;
            dat_meta_q     <= 1'b0;
            dat_sync_q     <= 1'b0;
`ifdef HC165_DEBOUNCE_EN
            cand_q         <= '0;
            cand_vld_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            gap_q          <= gap_d;
            bitcnt_q       <= bitcnt_d;
            shreg_q        <= shreg_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            data_changed_q <= data_changed_d;
            hc_ld_n_q      <= hc_ld_n_d;
            hc_clk_q       <= hc_clk_d;
            busy_q         <= busy_d;
            dat_meta_q     <= hc_dat;
            dat_sync_q     <= dat_meta_q;
`ifdef HC165_DEBOUNCE_EN
            cand_q         <= cand_d;
            cand_vld_q     <= cand_vld_d;
`endif
        end
    end

    assign hc_ld_n      = hc_ld_n_q;
    assign hc_clk       = hc_clk_q;
    assign data         = data_q;
    assign data_valid   = data_valid_q;
    assign data_changed = data_changed_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_hc165_scan_reader.sv
// Bench for hc165_scan_reader: behavioural '165 chain, schedule-position reference model,
// per-cycle comparator and directed scenarios (debounce scenario when HC165_DEBOUNCE_EN is defined).
module tb_hc165_scan_reader;

    localparam int N        = 16;
    localparam int D        = 4;
    localparam int G        = 20;
    localparam int DONE_POS = G + 2 * D * N;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b0;
    logic         scan_en = 1'b0;
    logic         hc_ld_n;
    logic         hc_clk;
    logic         hc_dat;
    logic [N-1:0] data;
    logic         data_valid;
    logic         data_changed;
    logic         busy;

    logic [N-1:0] preset = '0;
    logic [N-1:0] chain  = '0;

    int n_vec = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    hc165_scan_reader #(
        .CHAIN_BITS(N),
        .CLK_DIV   (D),
        .SCAN_GAP  (G)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .scan_en     (scan_en),
        .hc_ld_n     (hc_ld_n),
        .hc_clk      (hc_clk),
        .hc_dat      (hc_dat),
        .data        (data),
        .data_valid  (data_valid),
        .data_changed(data_changed),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // '165 chain: parallel load while SH/LD_n low, shift towards QH on each CLK rise.
    always @(posedge hc_clk or negedge hc_ld_n) begin
        if (!hc_ld_n) chain <= preset;
        else          chain <= {chain[N-2:0], 1'b0};
    end
    assign hc_dat = chain[N-1];

    // Reference model: position within the scan schedule plus the commit rules.
    int           m_pos     = 0;
    logic [N-1:0] m_word    = '0;
    logic [N-1:0] m_data    = '0;
    logic         m_valid   = 1'b0;
    logic         m_changed = 1'b0;
    logic [N-1:0] m_prev    = '0;
    logic         m_have    = 1'b0;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_pos = 0; m_word = '0; m_data = '0; m_valid = 1'b0;
            m_changed = 1'b0; m_prev = '0; m_have = 1'b0;
        end else begin
            m_valid   = 1'b0;
            m_changed = 1'b0;
            if (m_pos < G) begin
                m_pos = scan_en ? m_pos + 1 : 0;
            end else if (m_pos == DONE_POS) begin
`ifdef HC165_DEBOUNCE_EN
                if (m_have && m_word == m_prev) begin
                    m_changed = (m_word != m_data);
                    m_data    = m_word;
                    m_valid   = 1'b1;
                end
                m_prev = m_word;
                m_have = 1'b1;
`else
                m_changed = (m_word != m_data);
                m_data    = m_word;
                m_valid   = 1'b1;
`endif
                m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
            end
            if (m_pos == G) m_word = preset;
        end
    end

    function automatic logic exp_ld_n(input int pos);
        return !(pos >= G && pos < G + D);
    endfunction

    function automatic logic exp_clk(input int pos);
        return (pos >= G + D) && (pos < DONE_POS) && (((pos - G - D) / D) % 2 == 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            check("cmp_ld_n",    64'(hc_ld_n),      64'(exp_ld_n(m_pos)));
            check("cmp_clk",     64'(hc_clk),       64'(exp_clk(m_pos)));
            check("cmp_busy",    64'(busy),         64'(m_pos >= G));
            check("cmp_valid",   64'(data_valid),   64'(m_valid));
            check("cmp_changed", 64'(data_changed), 64'(m_changed));
            check("cmp_data",    64'(data),         64'(m_data));
        end
    end

    // Runs until the cycle busy falls (the commit cycle), tallying pin activity on the way.
    task automatic wait_scan(input int budget, output int cycles, output int rises, output int ld_low);
        logic prev_clk, prev_busy, done;
        cycles = 0; rises = 0; ld_low = 0; done = 1'b0;
        prev_clk = hc_clk; prev_busy = busy;
        while (!done && cycles < budget) begin
            @(negedge sys_clk);
            cycles++;
            if (hc_clk && !prev_clk) rises++;
            if (!hc_ld_n) ld_low++;
            if (prev_busy && !busy) done = 1'b1;
            prev_clk  = hc_clk;
            prev_busy = busy;
        end
        check("scan_done", 64'(done), 64'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, rises, ld_low, cnt;
        logic prev_clk;

        #1 sys_rst = 1'b1;
        cmp_en = 1'b1;
        #1;
        check("rst_ld_n",  64'(hc_ld_n),    64'd1);
        check("rst_clk",   64'(hc_clk),     64'd0);
        check("rst_data",  64'(data),       64'd0);
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_busy",  64'(busy),       64'd0);
        repeat (3) @(negedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("idle_no_load", 64'(hc_ld_n), 64'd1);

`ifdef HC165_DEBOUNCE_EN
        #1 preset = 16'h1234; scan_en = 1'b1;
        wait_scan(400, cyc, rises, ld_low);
        check("db1_valid", 64'(data_valid), 64'd0);
        wait_scan(400, cyc, rises, ld_low);
        check("db2_valid",   64'(data_valid),   64'd1);
        check("db2_changed", 64'(data_changed), 64'd1);
        check("db2_data",    64'(data),         64'h1234);
        #1 preset = 16'hFFFF;
        wait_scan(400, cyc, rises, ld_low);
        check("db3_valid", 64'(data_valid), 64'd0);
        check("db3_data",  64'(data),       64'h1234);
        #1 preset = 16'h1234;
        wait_scan(400, cyc, rises, ld_low);
        check("db4_valid", 64'(data_valid), 64'd0);
        wait_scan(400, cyc, rises, ld_low);
        check("db5_valid",   64'(data_valid),   64'd1);
        check("db5_changed", 64'(data_changed), 64'd0);
        check("db5_data",    64'(data),         64'h1234);
`else
        // First scan from enable: load after G cycles, commit after the full period.
        #1 preset = 16'hA5C3; scan_en = 1'b1;
        wait_scan(400, cyc, rises, ld_low);
        check("t1_latency", 64'(cyc),          64'd149);
        check("t1_valid",   64'(data_valid),   64'd1);
        check("t1_data",    64'(data),         64'hA5C3);
        check("t1_changed", 64'(data_changed), 64'd1);
        check("t1_rises",   64'(rises),        64'd15);
        check("t1_ld_low",  64'(ld_low),       64'd4);

        wait_scan(400, cyc, rises, ld_low);
        check("t2_period",  64'(cyc),          64'd149);
        check("t2_valid",   64'(data_valid),   64'd1);
        check("t2_changed", 64'(data_changed), 64'd0);
        check("t2_data",    64'(data),         64'hA5C3);

        #1 preset = 16'h0001;
        wait_scan(400, cyc, rises, ld_low);
        check("t3_lsb_data",    64'(data),         64'h0001);
        check("t3_lsb_changed", 64'(data_changed), 64'd1);
        #1 preset = 16'h8000;
        wait_scan(400, cyc, rises, ld_low);
        check("t3_msb_data",    64'(data),         64'h8000);
        check("t3_msb_changed", 64'(data_changed), 64'd1);

        // Reset during the 8th SHIFT_HI.
        #1 preset = 16'h3C5A;
        cnt = 0; rises = 0; prev_clk = hc_clk;
        while (rises < 8 && cnt < 300) begin
            @(negedge sys_clk);
            cnt++;
            if (hc_clk && !prev_clk) rises++;
            prev_clk = hc_clk;
        end
        check("t4_reach_hi8", 64'(rises), 64'd8);
        #1 sys_rst = 1'b1;
        #1;
        check("t4_rst_clk",  64'(hc_clk),  64'd0);
        check("t4_rst_ld_n", 64'(hc_ld_n), 64'd1);
        check("t4_rst_data", 64'(data),    64'd0);
        check("t4_rst_busy", 64'(busy),    64'd0);
        repeat (3) @(negedge sys_clk);
        #1 sys_rst = 1'b0;
        cnt = 0;
        while (hc_ld_n && cnt < 100) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("t4_load_delay", 64'(cnt), 64'd20);
        wait_scan(400, cyc, rises, ld_low);
        check("t4_data",    64'(data),         64'h3C5A);
        check("t4_changed", 64'(data_changed), 64'd1);

        // Drop scan_en mid-scan: the scan still commits, then the block stays idle.
        #1 preset = 16'h5AA5;
        cnt = 0;
        while (!busy && cnt < 100) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("t5_scan_start", 64'(busy), 64'd1);
        repeat (30) @(negedge sys_clk);
        #1 scan_en = 1'b0;
        wait_scan(400, cyc, rises, ld_low);
        check("t5_valid",   64'(data_valid),   64'd1);
        check("t5_data",    64'(data),         64'h5AA5);
        check("t5_changed", 64'(data_changed), 64'd1);
        ld_low = 0;
        repeat (400) begin
            @(negedge sys_clk);
            if (!hc_ld_n || busy) ld_low++;
        end
        check("t5_idle_hold", 64'(ld_low), 64'd0);
`endif

        repeat (2) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
